data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: ADDR_WORDS_LOG2, default 10, storage depth as log2 of 32-bit words.
REQ-002 Parameter: WAIT_CYCLES, default 2, legal 0..15, wait states inserted per access.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: mem_en  input  1  core M-stage access request valid.
REQ-006 Port: mem_wen  input  4  byte-lane write enables; 4'b0000 = read; bit i covers data bits [8i+7:8i].
REQ-007 Port: mem_addr  input  32  byte address; bits [1:0] ignored.
REQ-008 Port: mem_wdata  input  32  write data, lane-aligned.
REQ-009 Port: mem_rdata  output  32  registered full-word read data.
REQ-010 Port: mem_rvalid  output  1  one-cycle pulse, access complete, mem_rdata valid.
REQ-011 Port: mem_stall  output  1  holds the core pipeline while an access is outstanding.

Function
REQ-012 FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-013 IDLE with mem_en=0: mem_stall=0, state unchanged.
REQ-014 IDLE with mem_en=1: mem_stall=1 combinationally in the same cycle. Word index mem_addr[ADDR_WORDS_LOG2+1:2], mem_wen and mem_wdata latched at the edge.
REQ-015 From IDLE with mem_en=1: next state WAIT if WAIT_CYCLES>0, otherwise RESP; wait counter loaded with WAIT_CYCLES-1.
REQ-016 WAIT: mem_stall=1; counter decrements each cycle; at counter=0 next state is RESP.
REQ-017 Write commit: lanes with latched wen bit set SHALL be written on the edge entering RESP; unselected lanes unchanged.
REQ-018 RESP: mem_stall=0, mem_rvalid=1, mem_rdata = full word at the latched index after any write in REQ-017 (read-after-write).
REQ-019 RESP -> IDLE unconditionally; mem_en is sampled again in IDLE only.
REQ-020 Timing: stall high for 1+WAIT_CYCLES cycles; request-to-rvalid latency = WAIT_CYCLES+1 cycles; one access per WAIT_CYCLES+2 cycles at most.
REQ-021 Changes on mem_en, mem_wen, mem_addr or mem_wdata during WAIT/RESP SHALL be ignored.
REQ-022 Address bits above ADDR_WORDS_LOG2+1 ignored; indices wrap modulo 2^ADDR_WORDS_LOG2.
REQ-023 mem_rdata SHALL hold its last RESP value outside RESP; mem_rvalid=0 outside RESP.
REQ-024 No sub-word extraction or sign extension; the core selects bytes or halfwords using address bits [1:0].
REQ-025 Any nonzero mem_wen pattern is accepted as given; no misalignment checking.

Reset
REQ-026 While rst=1: state=IDLE, counter=0, mem_rdata=32'h0, mem_rvalid=0, mem_stall=0.
REQ-027 Reset asserted in WAIT SHALL abandon the access; its write SHALL NOT commit.
REQ-028 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-029 Shared package SHALL hold the state enumeration (IDLE/WAIT/RESP) and the wait-counter width constant (4 bits).
REQ-030 Storage SHALL be a sub-module dmem_ram: 2^ADDR_WORDS_LOG2 x 32, synchronous per-byte-lane write, one read port.
REQ-031 FSM, latches and counter SHALL reside in data_mem_responder.

Verification
REQ-032 WAIT_CYCLES=2. Write addr 0x10, wen 1111, wdata 0xDEADBEEF. Then read 0x10. Stall high 3 cycles per access; read rvalid with rdata 0xDEADBEEF.
REQ-033 Word 0x20 preloaded 0x11223344. Write wen 0001, wdata 0x000000AA, addr 0x22. Read 0x20 returns 0x112233AA; addr bits [1:0] ignored.
REQ-034 WAIT_CYCLES=0. Back-to-back mem_en=1: rvalid every 2nd cycle; stall high exactly 1 cycle per access.
REQ-035 rst asserted in the 2nd WAIT cycle of write 0x55555555 to 0x40, word previously 0x0. Outputs reset next edge; later read 0x40 returns 0x0.
REQ-036 ADDR_WORDS_LOG2=10. Write 0xCAFEF00D to 0x00001004. Read 0x00000004 returns 0xCAFEF00D (wrap).
REQ-037 Change mem_addr and mem_wdata during WAIT. Committed word and rdata reflect values latched in IDLE.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_responder_pkg
//   Shared definitions for the data-memory responder: the access FSM state
//   enumeration, the wait-state counter width and a byte-lane merge helper
//   used to form the read-after-write response word.
// -----------------------------------------------------------------------------
package data_mem_responder_pkg;

  // Access sequencing: accept in IDLE, burn wait states in WAIT, answer in RESP.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Wait-state counter width; holds WAIT_CYCLES-1 for WAIT_CYCLES up to 15.
  localparam int WAIT_CNT_W = 4;
  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

  // Replace the byte lanes selected by wen in old_word with those of new_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  wen);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_mem_responder_dmem_ram.sv
// -----------------------------------------------------------------------------
// dmem_ram
//   2^ADDR_WORDS_LOG2 x 32-bit word storage with a synchronous per-byte-lane
//   write and one combinational read port sharing the same word index.
//
// Ports
//   clk      in   clock; writes occur on the rising edge
//   we_i     in   [3:0] byte-lane write enables (bit i -> bits [8i+7:8i])
//   addr_i   in   word index for both write and read
//   wdata_i  in   [31:0] lane-aligned write data
//   rdata_o  out  [31:0] current contents of the addressed word
// -----------------------------------------------------------------------------
module dmem_ram #(
  parameter int ADDR_WORDS_LOG2 = 10
) (
  input  logic                       clk,
  input  logic [3:0]                 we_i,
  input  logic [ADDR_WORDS_LOG2-1:0] addr_i,
  input  logic [31:0]                wdata_i,
  output logic [31:0]                rdata_o
);

  localparam int DEPTH = 1 << ADDR_WORDS_LOG2;

  logic [31:0] mem_q [DEPTH];

  // NOTE: storage has no reset branch; clearing a RAM array on reset would
  // turn it into a flop bank and contents must survive reset anyway.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Data-memory slave for a pipelined core's M stage. An access is accepted in
//   IDLE (stall asserted combinationally), held for WAIT_CYCLES wait states,
//   and answered in RESP with a one-cycle rvalid pulse and the full addressed
//   word, including any bytes written by that same access.
//
// Parameters
//   ADDR_WORDS_LOG2  storage depth as log2 of 32-bit words
//   WAIT_CYCLES      wait states per access, 0..15
//
// Ports
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   mem_en      in   access request valid (sampled in IDLE only)
//   mem_wen     in   [3:0] byte-lane write enables, 0 = read
//   mem_addr    in   [31:0] byte address, bits [1:0] ignored
//   mem_wdata   in   [31:0] lane-aligned write data
//   mem_rdata   out  [31:0] registered response word, held between responses
//   mem_rvalid  out  one-cycle pulse in RESP
//   mem_stall   out  high while an access is outstanding
// -----------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WORDS_LOG2 = 10,
  parameter int WAIT_CYCLES     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        mem_stall
);

  localparam int AW = ADDR_WORDS_LOG2;
  localparam wait_cnt_t WAIT_LOAD = (WAIT_CYCLES > 0) ? wait_cnt_t'(WAIT_CYCLES - 1) : '0;

  state_e          state_q, state_d;
  wait_cnt_t       cnt_q,   cnt_d;
  logic [AW-1:0]   idx_q,   idx_d;
  logic [3:0]      wen_q,   wen_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [AW-1:0]   req_idx;
  logic [AW-1:0]   acc_idx;
  logic [3:0]      acc_wen;
  logic [31:0]     acc_wdata;
  logic            commit;
  logic            stall;
  logic            rvalid;
  logic [3:0]      ram_we;
  logic [31:0]     ram_rdata;

  // Upper address bits wrap the index; the byte offset is the core's business.
  assign req_idx = mem_addr[AW+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    commit    = 1'b0;
    stall     = 1'b0;
    rvalid    = 1'b0;
    // Outside IDLE the storage sees the latched request; in IDLE it sees the
    // live one, which matters when WAIT_CYCLES=0 commits on the accept edge.
    acc_idx   = idx_q;
    acc_wen   = wen_q;
    acc_wdata = wdata_q;

    unique case (state_q)
      IDLE: begin
        acc_idx   = req_idx;
        acc_wen   = mem_wen;
        acc_wdata = mem_wdata;
        if (mem_en) begin
          stall   = 1'b1;
          idx_d   = req_idx;
          wen_d   = mem_wen;
          wdata_d = mem_wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = RESP;
            cnt_d   = '0;
            commit  = 1'b1;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt_q == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - wait_cnt_t'(1);
        end
      end
      RESP: begin
        rvalid  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Response word is the stored word with this access's lanes merged in,
    // captured on the same edge that commits the write.
    if (commit) rdata_d = merge_lanes(ram_rdata, acc_wdata, acc_wen);

    // Reset quiets the outputs at once and blocks a write that would
    // otherwise land on the reset edge.
    if (rst) begin
      stall  = 1'b0;
      rvalid = 1'b0;
      commit = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wen_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign ram_we = commit ? acc_wen : 4'b0000;

  dmem_ram #(
    .ADDR_WORDS_LOG2(AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (acc_idx),
    .wdata_i (acc_wdata),
    .rdata_o (ram_rdata)
  );

  assign mem_rdata  = rdata_q;
  assign mem_rvalid = rvalid;
  assign mem_stall  = stall;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//   Two responders side by side: one with two wait states, one with none.
//   Expected words come from a per-instance word-addressed memory model;
//   expected timing comes from the wait-state count.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int AW    = 10;
  localparam int WORDS = 1 << AW;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en2, en0;
  logic [3:0]  wen;
  logic [31:0] addr, wdata;
  logic [31:0] rdata2, rdata0;
  logic        rvalid2, rvalid0, stall2, stall0;

  data_mem_responder #(.ADDR_WORDS_LOG2(AW), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .mem_en(en2), .mem_wen(wen), .mem_addr(addr),
    .mem_wdata(wdata), .mem_rdata(rdata2), .mem_rvalid(rvalid2), .mem_stall(stall2)
  );

  data_mem_responder #(.ADDR_WORDS_LOG2(AW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_en(en0), .mem_wen(wen), .mem_addr(addr),
    .mem_wdata(wdata), .mem_rdata(rdata0), .mem_rvalid(rvalid0), .mem_stall(stall0)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl2 [int];
  logic [31:0] mdl0 [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // sel=1 -> zero-wait instance, sel=0 -> two-wait instance
  function automatic logic get_stall(input bit sel);
    return sel ? stall0 : stall2;
  endfunction
  function automatic logic get_rvalid(input bit sel);
    return sel ? rvalid0 : rvalid2;
  endfunction
  function automatic logic [31:0] get_rdata(input bit sel);
    return sel ? rdata0 : rdata2;
  endfunction
  task automatic set_en(input bit sel, input logic v);
    if (sel) en0 = v; else en2 = v;
  endtask

  // Apply one access to the model; returns the word the response must carry.
  function automatic logic [31:0] model_access(input bit sel, input logic [3:0] w,
                                               input logic [31:0] a, input logic [31:0] d);
    int          idx;
    logic [31:0] old_w, mask, new_w;
    idx = int'((a / 4) % WORDS);
    if (sel) old_w = mdl0.exists(idx) ? mdl0[idx] : 32'h0;
    else     old_w = mdl2.exists(idx) ? mdl2[idx] : 32'h0;
    mask = 32'h0;
    for (int i = 0; i < 4; i++) if (w[i]) mask = mask | (32'hFF << (8 * i));
    new_w = (old_w & ~mask) | (d & mask);
    if (sel) mdl0[idx] = new_w; else mdl2[idx] = new_w;
    return new_w;
  endfunction

  // One complete access; inputs are scrambled while it is outstanding.
  task automatic access(input bit sel, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    int          wc;
    int          stalls;
    int          lat;
    int          cyc;
    logic [31:0] exp, got;
    wc = sel ? 0 : 2;
    stalls = 0; lat = -1; cyc = 0; got = 'x;
    exp = model_access(sel, w, a, d);
    @(posedge clk); #1;
    wen = w; addr = a; wdata = d; set_en(sel, 1'b1);
    while (lat < 0 && cyc < 40) begin
      @(negedge clk);
      if (get_stall(sel)) stalls++;
      if (get_rvalid(sel)) begin
        lat = cyc;
        got = get_rdata(sel);
      end
      @(posedge clk); #1;
      wen   = 4'($urandom);
      addr  = $urandom;
      wdata = $urandom;
      set_en(sel, (cyc + 1 <= wc) ? 1'($urandom_range(0, 1)) : 1'b0);
      cyc++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(wc + 1));
    check({tag, "/stall_cycles"}, 32'(stalls), 32'(wc + 1));
    check({tag, "/rdata"}, got, exp);
    @(negedge clk);
    check({tag, "/rvalid_low_after"}, 32'(get_rvalid(sel)), 32'd0);
    check({tag, "/rdata_hold"}, get_rdata(sel), exp);
  endtask

  initial begin
    logic [31:0] a;
    int          k;

    rst = 1'b1; en2 = 1'b0; en0 = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/stall2",  32'(stall2),  32'd0);
    check("reset/rvalid2", 32'(rvalid2), 32'd0);
    check("reset/rdata2",  rdata2,       32'h0);
    check("reset/stall0",  32'(stall0),  32'd0);
    check("reset/rvalid0", 32'(rvalid0), 32'd0);
    check("reset/rdata0",  rdata0,       32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int s = 0; s < 2; s++) begin
      // full-word write then read back
      access(s[0], 4'hF, 32'h10, 32'hDEADBEEF, "w10");
      access(s[0], 4'h0, 32'h10, 32'h0,        "r10");
      // single-lane write with nonzero byte offset
      access(s[0], 4'hF, 32'h20, 32'h11223344, "w20_full");
      access(s[0], 4'h1, 32'h22, 32'h000000AA, "w22_lane0");
      access(s[0], 4'h0, 32'h20, 32'h0,        "r20");
      // index wrap
      access(s[0], 4'hF, 32'h00001004, 32'hCAFEF00D, "w1004");
      access(s[0], 4'h0, 32'h00000004, 32'h0,        "r0004_wrap");
    end

    // Reset in the second wait state of a write abandons it.
    access(1'b0, 4'hF, 32'h40, 32'h0, "w40_zero");
    @(posedge clk); #1;
    wen = 4'hF; addr = 32'h40; wdata = 32'h55555555; en2 = 1'b1;
    @(posedge clk); #1;
    en2 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_wait/stall",  32'(stall2),  32'd0);
    check("rst_in_wait/rvalid", 32'(rvalid2), 32'd0);
    check("rst_in_wait/rdata",  rdata2,       32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    access(1'b0, 4'h0, 32'h40, 32'h0, "r40_after_rst");
    access(1'b0, 4'h0, 32'h10, 32'h0, "r10_retained");

    // Zero wait states, request held continuously.
    @(posedge clk); #1;
    wen = 4'h0; addr = 32'h10; en0 = 1'b1;
    for (k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("b2b/stall%0d", k),  32'(stall0),  32'((k % 2) == 0));
      check($sformatf("b2b/rvalid%0d", k), 32'(rvalid0), 32'((k % 2) == 1));
      if (k % 2 == 1) check($sformatf("b2b/rdata%0d", k), rdata0, mdl0[4]);
    end
    @(posedge clk); #1;
    en0 = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Randomized traffic over a small pre-written window, with random
    // upper address bits (wrap) and random byte offsets.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++)
        access(s[0], 4'hF, 32'h100 + 32'(4 * i), $urandom, "init");
      for (int i = 0; i < (s == 0 ? 40 : 30); i++) begin
        a = 32'h100 + 32'(4 * $urandom_range(0, 15));
        a = a | ($urandom << (AW + 2)) | 32'($urandom_range(0, 3));
        access(s[0], 4'($urandom_range(0, 15)), a, $urandom, "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
